// File: rtl/flex_updown_counter.sv
// flex_updown_counter: up/down counter with programmable step, synchronous clear/load,
// wrap-or-saturate range handling and registered rollover/zero/wrap flags.
module flex_updown_counter #(
    parameter int unsigned NUM_CNT_BITS = 4,
    parameter int unsigned STEP_BITS    = 2,
    parameter bit          SATURATE     = 1'b0
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    i_clear,
    input  logic                    i_load,
    input  logic [NUM_CNT_BITS-1:0] i_load_val,
    input  logic                    i_count_enable,
    input  logic                    i_count_up,
    input  logic [STEP_BITS-1:0]    i_step,
    input  logic [NUM_CNT_BITS-1:0] i_rollover_val,
    output logic [NUM_CNT_BITS-1:0] o_count_out,
    output logic                    o_rollover_flag,
    output logic                    o_zero_flag,
    output logic                    o_wrap_pulse
);

    // One bit wider than the widest operand so a carry or borrow is never lost.
    localparam int unsigned EXT_BITS =
        ((STEP_BITS > NUM_CNT_BITS) ? STEP_BITS : NUM_CNT_BITS) + 1;

    logic [EXT_BITS-1:0]     w_count_ext;
    logic [EXT_BITS-1:0]     w_step_ext;
    logic [EXT_BITS-1:0]     w_roll_ext;
    logic [EXT_BITS-1:0]     w_sum;
    logic [EXT_BITS-1:0]     w_diff;
    logic [NUM_CNT_BITS-1:0] w_load_clamped;
    logic [NUM_CNT_BITS-1:0] w_up_end;
    logic [NUM_CNT_BITS-1:0] w_down_end;
    logic [NUM_CNT_BITS-1:0] w_next;
    logic                    w_wrap;

    logic [NUM_CNT_BITS-1:0] r_count;
    logic                    r_rollover_flag;
    logic                    r_zero_flag;
    logic                    r_wrap_pulse;

    assign w_count_ext = EXT_BITS'(r_count);
    assign w_step_ext  = EXT_BITS'(i_step);
    assign w_roll_ext  = EXT_BITS'(i_rollover_val);
    assign w_sum       = w_count_ext + w_step_ext;
    assign w_diff      = w_count_ext - w_step_ext;

    // A load beyond the range bound lands on the bound.
    assign w_load_clamped = (i_load_val > i_rollover_val) ? i_rollover_val : i_load_val;

    // Where the count goes when an up or down step runs off the end of the range.
    assign w_up_end   = SATURATE ? i_rollover_val : {NUM_CNT_BITS{1'b0}};
    assign w_down_end = SATURATE ? {NUM_CNT_BITS{1'b0}} : i_rollover_val;

    // Next-count selection: clear > load > count > hold.
    always_comb begin
        w_next = r_count;
        w_wrap = 1'b0;
        if (i_clear) begin
            w_next = {NUM_CNT_BITS{1'b0}};
        end else if (i_load) begin
            w_next = w_load_clamped;
        end else if (i_count_enable && (w_step_ext != {EXT_BITS{1'b0}})) begin
            if (i_count_up) begin
                if (w_sum <= w_roll_ext) begin
                    w_next = NUM_CNT_BITS'(w_sum);
                end else begin
                    w_next = w_up_end;
                    w_wrap = 1'b1;
                end
            end else begin
                if (w_count_ext >= w_step_ext) begin
                    w_next = NUM_CNT_BITS'(w_diff);
                end else begin
                    w_next = w_down_end;
                    w_wrap = 1'b1;
                end
            end
        end
    end

    // Count and flags all register from the same next value so flags never lag the count.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count         <= {NUM_CNT_BITS{1'b0}};
            r_rollover_flag <= 1'b0;
            r_zero_flag     <= 1'b1;
            r_wrap_pulse    <= 1'b0;
        end else begin
            r_count         <= w_next;
            r_rollover_flag <= (w_next == i_rollover_val);
            r_zero_flag     <= (w_next == {NUM_CNT_BITS{1'b0}});
            r_wrap_pulse    <= w_wrap;
        end
    end

    assign o_count_out     = r_count;
    assign o_rollover_flag = r_rollover_flag;
    assign o_zero_flag     = r_zero_flag;
    assign o_wrap_pulse    = r_wrap_pulse;

endmodule
